neuron_accumulator_ctrl: RTL and testbench
==========================================

Name: neuron_accumulator_ctrl

Overview:
Sequences one shared signed adder to form a neuron pre-activation: bias + sum of NUM_TERMS signed terms.
- Terms arrive on a valid/ready stream; the result leaves on a valid/ready stream.
- Saturates to ACC_WIDTH and flags overflow.
- Sits between the weight-by-input multiplier stream and the activation stage.

Parameters:
DATA_WIDTH, 16, signed term width (two's complement)
ACC_WIDTH, 24, signed accumulator/result width; must be >= DATA_WIDTH
NUM_TERMS, 8, terms accumulated per neuron; must be >= 1

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  begin a neuron; sampled in IDLE, or in DONE during the result handshake
bias_in  input  ACC_WIDTH  signed bias, loaded on accepted start
term_in  input  DATA_WIDTH  signed term
term_valid_in  input  1  term_in valid
term_ready_out  output  1  controller accepts a term this cycle
result_out  output  ACC_WIDTH  saturated sum
result_valid_out  output  1  result_out valid
result_ready_in  input  1  consumer accepts result
overflow_out  output  1  sticky saturation flag for the current neuron; valid with result
busy_out  output  1  high in ACCUM or DONE
count_out  output  $clog2(NUM_TERMS+1)  terms accepted so far

Behaviour:
- Reset: clock is clk_in; reset is asynchronous, active-low on rst_n_in.
  - Asserting rst_n_in low at any time (including mid-ACCUM or in DONE) immediately forces state IDLE.
  - Accumulator, count_out, result_out, overflow_out, result_valid_out, term_ready_out and busy_out all go to 0.
  - Any partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - term_ready_out=0; result_valid_out=0.
  - If start_in=1: acc<=bias_in, count<=0, overflow<=0, next state ACCUM.
- ACCUM:
  - term_ready_out=1 (combinational from state).
  - On term_valid_in & term_ready_out: acc<=sat(acc + sext(term_in)), count<=count+1.
  - overflow<=overflow | sat_event.
  - When the accepted term is number NUM_TERMS (count==NUM_TERMS-1 before the edge), next state DONE.
  - Idle cycles (valid low) hold all state.
  - start_in is ignored.
- DONE:
  - result_valid_out=1; result_out=acc; term_ready_out=0.
  - result_out and overflow_out stay stable until the handshake completes.
  - On result_valid_out & result_ready_in:
    - If start_in=1 in the same cycle: reload bias_in, clear count/overflow, go to ACCUM (back-to-back neurons, no idle cycle).
    - Otherwise go to IDLE.
  - start_in without result_ready_in is ignored.
- Arithmetic:
  - Sum is computed at ACC_WIDTH+1 bits from sign-extended operands.
  - If the top two bits differ, clamp: positive overflow -> 2^(ACC_WIDTH-1)-1; negative -> -2^(ACC_WIDTH-1).
  - That clamp event is sat_event.
  - After saturation, accumulation continues from the clamped value.
- Latency:
  - result_valid_out rises on the edge that accepts the final term.
  - With term_valid_in held high, result_valid_out is high NUM_TERMS edges after the edge sampling start_in.
  - Throughput is one term per cycle.
- count_out equals NUM_TERMS in DONE, 0 in IDLE.

Decomposition:
- Shared package nn_pkg holds the state enum (acc_state_t: IDLE, ACCUM, DONE).
- nn_pkg also holds the saturation-bound helper functions (sat_max, sat_min as functions of width).
- One sub-module: the existing adder, instantiated with ADDEND_WIDTH=ACC_WIDTH and SUM_WIDTH=ACC_WIDTH+1 on sign-extended operands.
- Saturation and control logic remain in this block.

Test Plan:
Parameters for all scenarios: NUM_TERMS=4, DATA_WIDTH=16, ACC_WIDTH=24.
1. Basic sum: bias 10, terms 1,2,3,4 streamed continuously -> result_out 0x000014, overflow 0, result_valid_out high 4 edges after start sampled, count_out=4.
2. Negative sum: bias 0xFFFFFB (-5), terms 0x8000 x4 -> result_out 0xFDFFFB, overflow 0.
3. Saturation:
   - bias 0x7FFFF0, terms 0x7FFF x4 -> result_out 0x7FFFFF, overflow 1.
   - bias 0x800000, terms 0xFFFF x4 -> result_out 0x800000, overflow 1.
4. Backpressure:
   - term_valid_in toggled 1,0,1,0,... -> result 20 after 4 accepted terms; term_ready_out 0 in DONE.
   - result_ready_in held low 3 cycles -> result_out/overflow_out stable; start_in pulses ignored.
5. Reset mid-ACCUM: after 2 terms, pulse rst_n_in low asynchronously.
   - Outputs 0 immediately; state IDLE.
   - Then bias 0, terms 1,1,1,1 -> result 4 (no residue).
6. Back-to-back: in DONE assert result_ready_in and start_in (bias 100) together -> next edge in ACCUM with count 0; terms 0 x4 -> result 100; start_in during ACCUM has no effect.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron accumulation datapath:
// controller state encoding and signed saturation bounds for a given width.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/neuron_accumulator_ctrl_adder.sv
// Combinational two's-complement adder; operands are sign-extended to SUM_WIDTH
// so a SUM_WIDTH one bit wider than the addends never wraps.
module neuron_accumulator_ctrl_adder #(
  parameter int ADDEND_WIDTH = 24,
  parameter int SUM_WIDTH    = 25
) (
  input  logic [ADDEND_WIDTH-1:0] a,
  input  logic [ADDEND_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0]    sum
);

  assign sum = SUM_WIDTH'($signed(a)) + SUM_WIDTH'($signed(b));

endmodule

// File: rtl/neuron_accumulator_ctrl.sv
// Forms bias + sum of NUM_TERMS signed terms with one shared adder, saturating to ACC_WIDTH.
// One term per cycle; result held until consumer handshake, back-to-back start allowed in DONE.
module neuron_accumulator_ctrl
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_TERMS  = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               start_in,
  input  logic [ACC_WIDTH-1:0]               bias_in,
  input  logic [DATA_WIDTH-1:0]              term_in,
  input  logic                               term_valid_in,
  output logic                               term_ready_out,
  output logic [ACC_WIDTH-1:0]               result_out,
  output logic                               result_valid_out,
  input  logic                               result_ready_in,
  output logic                               overflow_out,
  output logic                               busy_out,
  output logic [$clog2(NUM_TERMS+1)-1:0]     count_out
);

  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [CW-1:0]        LAST_IDX = CW'(NUM_TERMS - 1);
  localparam logic [ACC_WIDTH-1:0] MAX_VAL  = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] MIN_VAL  = ACC_WIDTH'(sat_min(ACC_WIDTH));

  acc_state_t state, state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        count;
  logic                 overflow;

  logic load;
  logic accept;
  logic clear_count;

  logic [ACC_WIDTH-1:0] term_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 sat_event;
  logic [ACC_WIDTH-1:0] sum_sat;

  assign term_ext = ACC_WIDTH'($signed(term_in));

  neuron_accumulator_ctrl_adder #(
    .ADDEND_WIDTH (ACC_WIDTH),
    .SUM_WIDTH    (ACC_WIDTH + 1)
  ) u_adder (
    .a   (acc),
    .b   (term_ext),
    .sum (sum)
  );

  // The extra sum bit disagreeing with the result sign bit means the true sum left the range.
  assign sat_event = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign sum_sat   = !sat_event      ? sum[ACC_WIDTH-1:0] :
                     sum[ACC_WIDTH]  ? MIN_VAL : MAX_VAL;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    load             = 1'b0;
    accept           = 1'b0;
    clear_count      = 1'b0;
    term_ready_out   = 1'b0;
    result_valid_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          load      = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        term_ready_out = 1'b1;
        if (term_valid_in) begin
          accept = 1'b1;
          if (count == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        result_valid_out = 1'b1;
        if (result_ready_in) begin
          if (start_in) begin
            load      = 1'b1;
            state_nxt = ACCUM;
          end else begin
            clear_count = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      acc      <= bias_in;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc      <= sum_sat;
      count    <= count + CW'(1);
      overflow <= overflow | sat_event;
    end else if (clear_count) begin
      count    <= '0;
    end
  end

  assign result_out   = acc;
  assign overflow_out = overflow;
  assign count_out    = count;
  assign busy_out     = (state != IDLE);

endmodule

// File: tb/tb_neuron_accumulator_ctrl.sv
// Bench for neuron_accumulator_ctrl with NUM_TERMS=4: directed scenarios plus
// randomized neurons checked against an arithmetic reference model.
module tb_neuron_accumulator_ctrl;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int NT = 4;
  localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (AW - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] bias = '0;
  logic [DW-1:0] term = '0;
  logic          term_valid = 1'b0;
  logic          term_ready;
  logic [AW-1:0] result;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          overflow;
  logic          busy;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] tq[$];

  always #5 clk = ~clk;

  neuron_accumulator_ctrl #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .NUM_TERMS  (NT)
  ) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .start_in         (start),
    .bias_in          (bias),
    .term_in          (term),
    .term_valid_in    (term_valid),
    .term_ready_out   (term_ready),
    .result_out       (result),
    .result_valid_out (result_valid),
    .result_ready_in  (result_ready),
    .overflow_out     (overflow),
    .busy_out         (busy),
    .count_out        (count)
  );

  function automatic longint sx(input logic [AW-1:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: bias plus each queued term in order, clamping to the signed range after every add.
  function automatic void model(input logic [AW-1:0] b, output logic [AW-1:0] r, output logic o);
    longint a;
    a = sx(b, AW);
    o = 1'b0;
    foreach (tq[i]) begin
      a = a + sx(AW'(tq[i]), DW);
      if (a > MAXV) begin a = MAXV; o = 1'b1; end
      if (a < MINV) begin a = MINV; o = 1'b1; end
    end
    r = a[AW-1:0];
  endfunction

  // Called on a falling edge; returns on the falling edge after start was sampled.
  task automatic begin_neuron(input logic [AW-1:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: continuous, 1: valid toggles 1,0,1,0..., 2: random holes.
  task automatic stream(input int mode, output int edges);
    int  idx;
    bit  ph;
    bit  hole;
    idx   = 0;
    ph    = 1'b0;
    edges = 0;
    while (idx < tq.size() && edges < 64) begin
      hole = (mode == 1) ? ph : ((mode == 2) && ($urandom_range(0, 2) == 0));
      if (hole) begin
        term_valid = 1'b0;
        term       = DW'($urandom);
      end else begin
        term_valid = 1'b1;
        term       = tq[idx];
        idx++;
      end
      ph = !ph;
      @(negedge clk);
      edges++;
    end
    term_valid = 1'b0;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    total++;
    if ({busy, result_valid, term_ready, overflow, count, result} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b vld=%b rdy=%b ovf=%b cnt=%0d res=%h want all 0",
               busy, result_valid, term_ready, overflow, count, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    tq = '{16'd1, 16'd2, 16'd3, 16'd4};
    begin_neuron(24'd10);
    total++;
    if (busy !== 1'b1 || count !== 3'd0 || term_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_enter_accum got busy=%b cnt=%0d rdy=%b want 1 0 1", busy, count, term_ready);
    end
    for (int i = 0; i < NT; i++) begin
      term_valid = 1'b1;
      term       = tq[i];
      @(negedge clk);
      total++;
      if (result_valid !== (i == NT - 1)) begin
        bad++;
        $display("FAIL basic_latency term=%0d got vld=%b want %b", i, result_valid, i == NT - 1);
      end
    end
    term_valid = 1'b0;
    total++;
    if (result !== 24'h000014 || overflow !== 1'b0 || count !== 3'd4 || term_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got res=%h ovf=%b cnt=%0d rdy=%b want 000014 0 4 0",
               result, overflow, count, term_ready);
    end
    consume();
    total++;
    if (busy !== 1'b0 || count !== 3'd0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got busy=%b cnt=%0d vld=%b want 0 0 0", busy, count, result_valid);
    end
  endtask

  task automatic test_negative();
    int e;
    tq = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    begin_neuron(24'hFFFFFB);
    stream(0, e);
    total++;
    if (result_valid !== 1'b1 || result !== 24'hFDFFFB || overflow !== 1'b0) begin
      bad++;
      $display("FAIL negative_sum got vld=%b res=%h ovf=%b want 1 fdfffb 0", result_valid, result, overflow);
    end
    consume();
  endtask

  task automatic test_saturation();
    int e;
    tq = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    begin_neuron(24'h7FFFF0);
    stream(0, e);
    total++;
    if (result_valid !== 1'b1 || result !== 24'h7FFFFF || overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_positive got vld=%b res=%h ovf=%b want 1 7fffff 1", result_valid, result, overflow);
    end
    consume();
    tq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    begin_neuron(24'h800000);
    stream(0, e);
    total++;
    if (result_valid !== 1'b1 || result !== 24'h800000 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_negative got vld=%b res=%h ovf=%b want 1 800000 1", result_valid, result, overflow);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int e;
    tq = '{16'd1, 16'd2, 16'd3, 16'd4};
    begin_neuron(24'd10);
    stream(1, e);
    total++;
    if (result_valid !== 1'b1 || result !== 24'd20 || term_ready !== 1'b0 || e !== 7) begin
      bad++;
      $display("FAIL bp_toggle got vld=%b res=%0d rdy=%b edges=%0d want 1 20 0 7",
               result_valid, result, term_ready, e);
    end
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      bias  = 24'h123456;
      @(negedge clk);
      total++;
      if (result_valid !== 1'b1 || result !== 24'd20 || overflow !== 1'b0 || count !== 3'd4) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got vld=%b res=%0d ovf=%b cnt=%0d want 1 20 0 4",
                 i, result_valid, result, overflow, count);
      end
    end
    start = 1'b0;
    consume();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    begin_neuron(24'h7FFFF0);
    for (int i = 0; i < 2; i++) begin
      term_valid = 1'b1;
      term       = 16'h7FFF;
      @(negedge clk);
    end
    term_valid = 1'b0;
    total++;
    if (count !== 3'd2 || overflow !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre got cnt=%0d ovf=%b busy=%b want 2 1 1", count, overflow, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, result_valid, term_ready, overflow, count, result} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got busy=%b vld=%b rdy=%b ovf=%b cnt=%0d res=%h want all 0",
               busy, result_valid, term_ready, overflow, count, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tq = '{16'd1, 16'd1, 16'd1, 16'd1};
    begin_neuron(24'd0);
    stream(0, e);
    total++;
    if (result_valid !== 1'b1 || result !== 24'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrst_fresh got vld=%b res=%0d ovf=%b want 1 4 0", result_valid, result, overflow);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int e;
    tq = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    begin_neuron(24'h7FFFF0);
    stream(0, e);
    result_ready = 1'b1;
    start        = 1'b1;
    bias         = 24'd100;
    @(negedge clk);
    result_ready = 1'b0;
    bias         = 24'h55AA55;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || count !== 3'd0 || term_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_enter got vld=%b busy=%b cnt=%0d rdy=%b want 0 1 0 1",
               result_valid, busy, count, term_ready);
    end
    // start stays high throughout ACCUM and must not restart the neuron.
    for (int i = 0; i < NT; i++) begin
      term_valid = 1'b1;
      term       = 16'd0;
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (count !== 3'd2) begin
          bad++;
          $display("FAIL b2b_start_ignored got cnt=%0d want 2", count);
        end
      end
    end
    term_valid = 1'b0;
    total++;
    if (result_valid !== 1'b1 || result !== 24'd100 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result got vld=%b res=%0d ovf=%b want 1 100 0", result_valid, result, overflow);
    end
    @(negedge clk);
    total++;
    if (result_valid !== 1'b1 || result !== 24'd100) begin
      bad++;
      $display("FAIL b2b_start_no_ready got vld=%b res=%0d want 1 100", result_valid, result);
    end
    start = 1'b0;
    consume();
  endtask

  task automatic test_random();
    int            e;
    int            mode;
    logic [AW-1:0] b;
    logic [AW-1:0] exp_r;
    logic          exp_o;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       b = 24'h7FF000 + AW'($urandom_range(0, 4095));
        1:       b = 24'h800000 + AW'($urandom_range(0, 4095));
        default: b = AW'($urandom);
      endcase
      tq.delete();
      for (int i = 0; i < NT; i++) begin
        tq.push_back(($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000)
                                                 : DW'($urandom));
      end
      model(b, exp_r, exp_o);
      mode = $urandom_range(0, 2);
      begin_neuron(b);
      stream(mode, e);
      for (int d = $urandom_range(0, 3); d > 0; d--) @(negedge clk);
      total++;
      if (result_valid !== 1'b1 || result !== exp_r || overflow !== exp_o || count !== 3'd4) begin
        bad++;
        $display("FAIL random_neuron n=%0d got vld=%b res=%h ovf=%b cnt=%0d want 1 %h %b 4",
                 n, result_valid, result, overflow, count, exp_r, exp_o);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
